// File: rtl/seg_display_scan.sv
// Four-digit seven-segment scan controller: prescaled digit slots, frame-aligned
// double-buffered value/dp updates, leading-zero blanking and anode guard time.
module seg_display_scan #(
  parameter int unsigned CLK_DIV = 100000,
  parameter int unsigned GUARD   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp_n,
  output logic        frame
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD);

  logic [CntW-1:0] cnt_q;
  logic [1:0]      idx_q;
  logic [15:0]     pend_val_q;
  logic [3:0]      pend_dp_q;
  logic            pend_flag_q;
  logic [15:0]     disp_val_q;
  logic [3:0]      disp_dp_q;
  logic            blank_q;

  logic            slot_end;
  logic            boundary;
  logic [3:0]      zero_dig;
  logic [3:0]      blanked;
  logic            in_guard;

  assign slot_end = (cnt_q == CntMax);
  assign boundary = slot_end && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      pend_val_q  <= 16'h0000;
      pend_dp_q   <= 4'h0;
      pend_flag_q <= 1'b0;
      disp_val_q  <= 16'h0000;
      disp_dp_q   <= 4'h0;
      blank_q     <= 1'b0;
    end else begin
      // blank_lz is registered so the outputs depend on state only
      blank_q <= blank_lz;
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (boundary) begin
        pend_flag_q <= 1'b0;
        if (load) begin
          disp_val_q <= value;
          disp_dp_q  <= dp;
        end else if (pend_flag_q) begin
          disp_val_q <= pend_val_q;
          disp_dp_q  <= pend_dp_q;
        end
      end else if (load) begin
        pend_val_q  <= value;
        pend_dp_q   <= dp;
        pend_flag_q <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      zero_dig[i] = (disp_val_q[4*i +: 4] == 4'h0) && !disp_dp_q[i];
    end
    // A digit blanks only if everything above it is blank as well
    blanked[3] = blank_q && zero_dig[3];
    blanked[2] = blanked[3] && zero_dig[2];
    blanked[1] = blanked[2] && zero_dig[1];
    blanked[0] = 1'b0;
  end

  assign in_guard = (cnt_q < GuardCnt);

  always_comb begin
    digit = disp_val_q[{idx_q, 2'b00} +: 4];
    if (in_guard || blanked[idx_q]) begin
      an = 4'b1111;
    end else begin
      an = ~(4'b0001 << idx_q);
    end
    dp_n  = (an != 4'b1111) ? ~disp_dp_q[idx_q] : 1'b1;
    frame = boundary;
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan: directed scenarios plus randomized
// traffic, compared against a time-based behavioural model of the display.
module tb_seg_display_scan;

  localparam int CD = 8;
  localparam int GD = 2;
  localparam int FR = 4 * CD;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        dp_n;
  logic        frame;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_display_scan #(
    .CLK_DIV(CD),
    .GUARD  (GD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .dp      (dp),
    .load    (load),
    .blank_lz(blank_lz),
    .digit   (digit),
    .an      (an),
    .dp_n    (dp_n),
    .frame   (frame)
  );

  // Model: t counts cycles since reset; slot/position derive from t arithmetically.
  int          t;
  logic [15:0] m_pv, m_dv;
  logic [3:0]  m_pd, m_dd;
  logic        m_pf, m_bl;

  always @(posedge clk) begin
    if (reset) begin
      t    <= 0;
      m_pv <= 16'h0;
      m_dv <= 16'h0;
      m_pd <= 4'h0;
      m_dd <= 4'h0;
      m_pf <= 1'b0;
      m_bl <= 1'b0;
    end else begin
      t    <= t + 1;
      m_bl <= blank_lz;
      if (t % FR == FR - 1) begin
        if (load) begin
          m_dv <= value;
          m_dd <= dp;
        end else if (m_pf) begin
          m_dv <= m_pv;
          m_dd <= m_pd;
        end
        m_pf <= 1'b0;
      end else if (load) begin
        m_pv <= value;
        m_pd <= dp;
        m_pf <= 1'b1;
      end
    end
  end

  function automatic int cur_slot();
    return (t / CD) % 4;
  endfunction

  function automatic int cur_pos();
    return t % CD;
  endfunction

  // Expected {digit, an, dp_n, frame}
  function automatic logic [9:0] exp_out();
    int         s = cur_slot();
    int         p = cur_pos();
    logic       bl = 1'b0;
    logic [3:0] nib;
    logic [3:0] an_e;
    logic       dpn;
    if (m_bl && s >= 1) begin
      bl = 1'b1;
      for (int j = s; j < 4; j++) begin
        if (m_dv[4*j +: 4] != 4'h0 || m_dd[j]) bl = 1'b0;
      end
    end
    nib  = 4'((m_dv >> (4 * s)) & 16'h000F);
    an_e = (p < GD || bl) ? 4'b1111 : ~(4'b0001 << s);
    dpn  = (an_e != 4'b1111) ? ~m_dd[s] : 1'b1;
    return {nib, an_e, dpn, (s == 3 && p == CD - 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to(input int s, input int p);
    int n = 0;
    while (!(cur_slot() == s && cur_pos() == p) && n < 4 * FR) begin
      tick();
      n++;
    end
    checks++;
    if (!(cur_slot() == s && cur_pos() == p)) begin
      failures++;
      $display("FAIL run_to_timeout got slot=%0d pos=%0d want slot=%0d pos=%0d",
               cur_slot(), cur_pos(), s, p);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp    = d;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; value = '0; dp = '0; blank_lz = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({an, dp_n, frame} !== 6'b111110) begin
        failures++;
        $display("FAIL reset_hold got an=%b dp_n=%b frame=%b want 1111/1/0", an, dp_n, frame);
      end
    end
    reset = 1'b0;
    for (int k = 0; k < CD; k++) begin
      checks++;
      if (an !== ((k < GD) ? 4'b1111 : 4'b1110) || digit !== 4'h0) begin
        failures++;
        $display("FAIL reset_release cyc=%0d got an=%b digit=%h", k, an, digit);
      end
      checks++;
      if ({digit, an, dp_n, frame} !== exp_out()) begin
        failures++;
        $display("FAIL reset_model t=%0d got=%h want=%h", t, {digit, an, dp_n, frame}, exp_out());
      end
      tick();
    end
  endtask

  task automatic test_buffered_load();
    logic [3:0] ed [4] = '{4'h4, 4'hA, 4'h2, 4'h1};
    run_to(1, 3);
    do_load(16'h12A4, 4'h0);
    for (int k = 0; k < FR && (t % FR) != 0; k++) begin
      checks++;
      if (digit !== 4'h0) begin
        failures++;
        $display("FAIL buf_hold t=%0d got digit=%h want 0", t, digit);
      end
      tick();
    end
    for (int k = 0; k < FR; k++) begin
      if (cur_pos() == 3) begin
        checks++;
        if (digit !== ed[cur_slot()] || an !== ~(4'b0001 << cur_slot())) begin
          failures++;
          $display("FAIL buf_show slot=%0d got digit=%h an=%b", cur_slot(), digit, an);
        end
      end
      checks++;
      if ({digit, an, dp_n, frame} !== exp_out()) begin
        failures++;
        $display("FAIL buf_model t=%0d got=%h want=%h", t, {digit, an, dp_n, frame}, exp_out());
      end
      tick();
    end
  endtask

  task automatic test_blanking();
    blank_lz = 1'b1;
    run_to(1, 0);
    do_load(16'h0070, 4'h0);
    run_to(0, 0);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if ((cur_slot() >= 2 && an !== 4'b1111) ||
          (cur_slot() == 1 && cur_pos() >= GD && (an !== 4'b1101 || digit !== 4'h7)) ||
          (cur_slot() == 0 && cur_pos() >= GD && (an !== 4'b1110 || digit !== 4'h0))) begin
        failures++;
        $display("FAIL blank_0070 slot=%0d pos=%0d got an=%b digit=%h",
                 cur_slot(), cur_pos(), an, digit);
      end
      tick();
    end
    run_to(1, 0);
    do_load(16'h0000, 4'h0);
    run_to(0, 0);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if ({digit, an, dp_n, frame} !== exp_out() ||
          (cur_slot() >= 1 && an !== 4'b1111)) begin
        failures++;
        $display("FAIL blank_0000 t=%0d got=%h want=%h", t, {digit, an, dp_n, frame}, exp_out());
      end
      tick();
    end
  endtask

  task automatic test_dp_blank();
    blank_lz = 1'b1;
    run_to(1, 0);
    do_load(16'h0000, 4'b0100);
    run_to(0, 0);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if ((cur_slot() == 3 && an !== 4'b1111) ||
          (cur_slot() == 2 && cur_pos() >= GD && {digit, an, dp_n} !== {4'h0, 4'b1011, 1'b0}) ||
          (cur_slot() == 1 && cur_pos() >= GD && {digit, an, dp_n} !== {4'h0, 4'b1101, 1'b1})) begin
        failures++;
        $display("FAIL dp_blank slot=%0d pos=%0d got an=%b digit=%h dp_n=%b",
                 cur_slot(), cur_pos(), an, digit, dp_n);
      end
      checks++;
      if ({digit, an, dp_n, frame} !== exp_out()) begin
        failures++;
        $display("FAIL dp_model t=%0d got=%h want=%h", t, {digit, an, dp_n, frame}, exp_out());
      end
      tick();
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_to(1, 2);
    do_load(16'h1111, 4'h0);
    run_to(3, CD - 1);
    checks++;
    if (frame !== 1'b1) begin
      failures++;
      $display("FAIL frame_pulse got frame=%b want 1", frame);
    end
    do_load(16'h2222, 4'h0);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (digit !== 4'h2) begin
        failures++;
        $display("FAIL collision t=%0d got digit=%h want 2", t, digit);
      end
      tick();
    end
    run_to(1, 0);
    do_load(16'h3333, 4'h0);
    run_to(2, 4);
    do_load(16'h4444, 4'h0);
    run_to(0, 0);
    for (int k = 0; k < FR; k++) begin
      checks++;
      if (digit !== 4'h4) begin
        failures++;
        $display("FAIL last_wins t=%0d got digit=%h want 4", t, digit);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    run_to(1, 1);
    do_load(16'h5678, 4'hF);
    run_to(2, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({digit, an, dp_n, frame} !== {4'h0, 4'b1111, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_state got digit=%h an=%b dp_n=%b frame=%b",
               digit, an, dp_n, frame);
    end
    for (int k = 0; k < 2 * FR; k++) begin
      checks++;
      if (digit !== 4'h0 || dp_n !== 1'b1 || {digit, an, dp_n, frame} !== exp_out()) begin
        failures++;
        $display("FAIL reset_mid_discard t=%0d got=%h want=%h",
                 t, {digit, an, dp_n, frame}, exp_out());
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int k = 0; k < 1200; k++) begin
      v = 16'($urandom);
      for (int n = 0; n < 4; n++) begin
        if ($urandom_range(0, 1) == 0) v[4*n +: 4] = 4'h0;
      end
      value = v;
      dp    = 4'($urandom & $urandom);
      load  = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
      tick();
      checks++;
      if ({digit, an, dp_n, frame} !== exp_out()) begin
        failures++;
        $display("FAIL random t=%0d got=%h want=%h", t, {digit, an, dp_n, frame}, exp_out());
      end
    end
    load  = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_buffered_load();
    test_blanking();
    test_dp_blank();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

Time-multiplexed scan controller for the four-digit seven-segment display. Holds a 16-bit hex value and cycles through the digits, presenting one 4-bit nibble per slot to the downstream hex-to-segment decoder and driving the matching active-low anode. Value updates are double-buffered and applied only at frame boundaries, so a digit never shows a torn value. Also provides leading-zero blanking, per-digit decimal points, and anode guard time against ghosting.

## Interface
Parameters:
- CLK_DIV, 100000: clock cycles per digit slot; must be ≥ 2.
- GUARD, 2: cycles at the start of each slot with all anodes off; must satisfy 0 ≤ GUARD < CLK_DIV.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  16  hex digits to display; digit 0 (rightmost) = value[3:0], digit 3 = value[15:12].
- dp  in  4  decimal-point request per digit, active high; dp[i] belongs to digit i.
- load  in  1  one-cycle strobe that captures value and dp.
- blank_lz  in  1  leading-zero blanking enable.
- digit  out  4  nibble for the current slot, fed to the segment decoder.
- an  out  4  anode enables, active low; an[i] = 0 lights digit i.
- dp_n  out  1  decimal point, active low.
- frame  out  1  one-cycle pulse in the last cycle of each slot-3 period.

## Operation
- State: prescaler cnt (0..CLK_DIV-1), slot index idx (0..3), pending registers (pend_val, pend_dp, pend_flag), and display registers (disp_val, disp_dp).
- Counting:
  - cnt increments each cycle.
  - At cnt = CLK_DIV-1, cnt wraps to 0 and idx advances 0→1→2→3→0.
- Load:
  - load = 1 writes value/dp into pend_val/pend_dp and sets pend_flag.
  - Several loads before a boundary: the last one wins.
- Frame boundary (cnt = CLK_DIV-1 and idx = 3):
  - frame = 1 during that cycle.
  - On the next edge: if load = 1 in the same cycle, the inputs go straight into disp_val/disp_dp; otherwise, if pend_flag = 1, pend_* go into disp_*.
  - pend_flag clears in both cases.
  - Display registers change at no other time.
- Blanking (blank_lz = 1): digit i is blanked iff i ≥ 1, disp_val nibble i = 0, disp_dp[i] = 0, and every digit above i is also blanked (i = 3 needs only the first three conditions). Digit 0 is never blanked.
- With blank_lz = 0, nothing is blanked.
- Outputs are Moore decode of registered state, with no combinational path from inputs:
  - digit = disp_val nibble idx.
  - an = 4'b1111 if cnt < GUARD or the current digit is blanked; otherwise it is one-hot low at bit idx.
  - dp_n = ~disp_dp[idx] while an ≠ 4'b1111, else 1.
- Reset:
  - cnt = 0, idx = 0; all pending and display registers = 0; pend_flag = 0.
  - Outputs therefore start at an = 4'b1111, digit = 0, dp_n = 1, frame = 0.
  - Reset overrides load and any boundary in the same cycle.

## Timing
- Slot length is CLK_DIV cycles; frame length is 4·CLK_DIV cycles. At 100 MHz with the default CLK_DIV, each digit refreshes at 250 Hz.
- Load-to-display latency:
  - Minimum 1 cycle (load in the boundary cycle).
  - Maximum 4·CLK_DIV cycles (load in the cycle right after a boundary).
- The first slot after reset release is slot 0 with cnt = 0; an stays 4'b1111 for GUARD cycles.
- A reset mid-slot, or mid-frame with a load pending, discards the pending data; no update is applied at the following boundary.

## Test plan
Bench uses CLK_DIV = 8, GUARD = 2.
- Reset: hold reset 3 cycles, then release → an = 1111, dp_n = 1, frame = 0 while in reset; after release, cycles 0–1 an = 1111, cycles 2–7 an = 1110, digit = 0.
- Buffered load: load value 16'h12A4 in slot 1 → digits keep showing 0 until frame pulses; then slot 0 digit = 4/an = 1110, slot 1 A/1101, slot 2 2/1011, slot 3 1/0111.
- Leading-zero blanking: blank_lz = 1, load 16'h0070 → slots 2 and 3 an = 1111 for the whole slot; slot 1 digit = 7; slot 0 digit = 0 lit. Load 16'h0000 → only slot 0 lit.
- Decimal point stops blanking: blank_lz = 1, value 16'h0000, dp = 4'b0100 → slot 3 blanked; slot 2 digit = 0 with an = 1011 and dp_n = 0 after guard; slot 1 lit showing 0 with dp_n = 1.
- Boundary collision and last-wins: load 16'h1111 mid-frame, then 16'h2222 in the frame cycle → next slot 0 shows 2. Separately, loads of 16'h3333 then 16'h4444 within one frame → 4444 displayed.
- Reset mid-operation: with a load pending at idx = 2, cnt = 5, assert reset 1 cycle → state returns to the reset values, and the next frame still shows 0 on all digits.
